// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_e  - serializer FSM states; PARITY exists only when
//              PISO_SERIALIZER_PARITY_EN is defined.
//   clog2()  - counter width for a given word width (never below 1).
package serializer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1
`ifdef PISO_SERIALIZER_PARITY_EN
      ,
      PARITY = 2'd2
`endif
   } state_e;

   // Bits needed to hold the values 0..n-1, clamped to at least 1 bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serializer_bit_counter.sv
// Bit counter for the serializer: loads DATA_W-1 and counts down to zero.
// Latency: zero flag reflects the registered count (1 cycle after load/dec).
// Backpressure: none; only steps when dec_i is asserted.
//
// Ports:
//   in_clock, in_reset_n - clock, async active-low reset (count cleared to 0)
//   load_i               - load DATA_W-1 (takes priority over dec_i)
//   dec_i                - decrement by one; saturates at zero
//   zero_o               - count is zero
module serializer_bit_counter
   import serializer_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic in_clock,
   input  logic in_reset_n,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int CNT_W = clog2(DATA_W);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with optional trailing even-parity bit.
// Latency: first serial bit appears the cycle after a word is accepted.
// Backpressure: out_ready only while idle or while the final bit is consumed;
//               serial side advances only on in_enable.
//
// Ports:
//   in_clock, in_reset_n      - clock, async active-low reset
//   in_valid, in_data         - parallel word offered for loading
//   out_ready                 - word is accepted this cycle when in_valid
//   in_enable                 - consume the bit currently on out_bit
//   out_bit, out_bit_valid    - serial bit and its qualifier
//   out_last                  - out_bit is the final bit of the frame
// Build option: define PISO_SERIALIZER_PARITY_EN to append an even-parity bit
// (XOR of the data bits) after the data; frames then cannot run back-to-back.
module piso_serializer
   import serializer_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic              in_clock,
   input  logic              in_reset_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_ready,
   input  logic              in_enable,
   output logic              out_bit,
   output logic              out_bit_valid,
   output logic              out_last
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic              head_bit;
   logic [DATA_W-1:0] sr_shifted;
   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;
`ifdef PISO_SERIALIZER_PARITY_EN
   logic              par_q, par_d;
`endif

   serializer_bit_counter #(
      .DATA_W (DATA_W)
   ) u_bit_counter (
      .in_clock   (in_clock),
      .in_reset_n (in_reset_n),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // The bit on the wire always sits at the outgoing end of the register,
   // so advancing is a plain shift toward that end.
   always_comb begin
      if (MSB_FIRST != 0) begin
         head_bit   = sr_q[DATA_W-1];
         sr_shifted = {sr_q[DATA_W-2:0], 1'b0};
      end else begin
         head_bit   = sr_q[0];
         sr_shifted = {1'b0, sr_q[DATA_W-1:1]};
      end
   end

   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      cnt_load      = 1'b0;
      cnt_dec       = 1'b0;
      out_ready     = 1'b0;
      out_bit       = 1'b0;
      out_bit_valid = 1'b0;
      out_last      = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_d         = par_q;
`endif

      case (state_q)
         IDLE: begin
            // Reset forces IDLE asynchronously; keep ready low while held.
            out_ready = in_reset_n;
         end

         SHIFT: begin
            out_bit_valid = 1'b1;
            out_bit       = head_bit;
`ifndef PISO_SERIALIZER_PARITY_EN
            out_last      = cnt_zero;
`endif
            if (in_enable) begin
               if (cnt_zero) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                  state_d = PARITY;
`else
                  // Last bit leaves this cycle: a new word may take its place.
                  out_ready = 1'b1;
                  state_d   = IDLE;
`endif
               end else begin
                  sr_d    = sr_shifted;
                  cnt_dec = 1'b1;
               end
            end
         end

`ifdef PISO_SERIALIZER_PARITY_EN
         PARITY: begin
            out_bit_valid = 1'b1;
            out_bit       = par_q;
            out_last      = 1'b1;
            if (in_enable) begin
               state_d = IDLE;
            end
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase

      // Accept overrides the IDLE/SHIFT decision above, giving back-to-back
      // frames when a word arrives as the last bit is consumed.
      if (in_valid && out_ready) begin
         sr_d     = in_data;
         cnt_load = 1'b1;
         state_d  = SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
         par_d    = ^in_data;
`endif
      end
   end

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
`ifdef PISO_SERIALIZER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first and LSB-first) share
// one stimulus; a queue-of-bits frame model is compared every cycle, and
// directed scenarios check captured serial streams against literal values.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       in_clock;
   logic       in_reset_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_enable;

   logic m_ready, m_bit, m_valid, m_last;
   logic l_ready, l_bit, l_valid, l_last;

   piso_serializer #(.DATA_W(8), .MSB_FIRST(1)) dut_m (
      .in_clock      (in_clock),
      .in_reset_n    (in_reset_n),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .out_ready     (m_ready),
      .in_enable     (in_enable),
      .out_bit       (m_bit),
      .out_bit_valid (m_valid),
      .out_last      (m_last)
   );

   piso_serializer #(.DATA_W(8), .MSB_FIRST(0)) dut_l (
      .in_clock      (in_clock),
      .in_reset_n    (in_reset_n),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .out_ready     (l_ready),
      .in_enable     (in_enable),
      .out_bit       (l_bit),
      .out_bit_valid (l_valid),
      .out_last      (l_last)
   );

   initial in_clock = 1'b0;
   always #5 in_clock = ~in_clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame model: queue of bits still to be sent ----------
   typedef struct packed {
      logic b;
      logic last;
   } mbit_t;

   mbit_t qm[$];
   mbit_t ql[$];
   logic  r_model;

   function automatic logic model_ready();
      return in_reset_n && ((qm.size() == 0) || (!PAR && qm.size() == 1 && in_enable));
   endfunction

   task automatic push_frame(input logic [7:0] w);
      for (int k = 0; k < 8; k++) begin
         qm.push_back('{b: w[7-k], last: (k == 7) && !PAR});
         ql.push_back('{b: w[k],   last: (k == 7) && !PAR});
      end
      if (PAR) begin
         qm.push_back('{b: ^w, last: 1'b1});
         ql.push_back('{b: ^w, last: 1'b1});
      end
   endtask

   always @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         qm.delete();
         ql.delete();
      end else begin
         r_model = model_ready();
         if (qm.size() > 0 && in_enable) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
         end
         if (in_valid && r_model) push_frame(in_data);
      end
   end

   // ---------------- per-cycle comparison against the model ---------------
   always @(negedge in_clock) begin
      logic ev, em_b, em_l, el_b, el_l, er;
      ev   = (qm.size() > 0);
      em_b = ev ? qm[0].b    : 1'b0;
      em_l = ev ? qm[0].last : 1'b0;
      el_b = ev ? ql[0].b    : 1'b0;
      el_l = ev ? ql[0].last : 1'b0;
      er   = model_ready();
      check("m_ready", 32'(m_ready), 32'(er));
      check("m_valid", 32'(m_valid), 32'(ev));
      check("m_bit",   32'(m_bit),   32'(em_b));
      check("m_last",  32'(m_last),  32'(em_l));
      check("l_ready", 32'(l_ready), 32'(er));
      check("l_valid", 32'(l_valid), 32'(ev));
      check("l_bit",   32'(l_bit),   32'(el_b));
      check("l_last",  32'(l_last),  32'(el_l));
   end

   // ---------------- capture of consumed bits for literal checks ----------
   logic [15:0] cap_m, cap_l, last_m;
   int          ncap, vcnt;

   always @(negedge in_clock) begin
      if (m_valid) vcnt++;
      if (m_valid && in_enable) begin
         cap_m  = {cap_m[14:0], m_bit};
         cap_l  = {cap_l[14:0], l_bit};
         last_m = {last_m[14:0], m_last};
         ncap++;
      end
   end

   task automatic clear_cap();
      cap_m  = '0;
      cap_l  = '0;
      last_m = '0;
      ncap   = 0;
      vcnt   = 0;
   endtask

   task automatic tick();
      @(posedge in_clock);
      #1;
   endtask

   task automatic settle();
      @(negedge in_clock);
      #1;
   endtask

   task automatic accept(input logic [7:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int ens;
      in_reset_n = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      in_enable  = 1'b0;
      clear_cap();

      // Reset: all outputs low while held, ready right after release.
      repeat (3) tick();
      check("rst_ready", 32'(m_ready), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      in_reset_n = 1'b1;
      settle();
      check("post_rst_ready", 32'(m_ready), 32'd1);
      check("post_rst_bit",   32'(m_bit),   32'd0);

`ifndef PISO_SERIALIZER_PARITY_EN
      // 0xA5, enable held high.
      in_enable = 1'b1;
      clear_cap();
      accept(8'hA5);
      repeat (8) tick();
      settle();
      check("a5_count",    32'(ncap),        32'd8);
      check("a5_msb_bits", 32'(cap_m[7:0]),  32'h0A5);
      check("a5_lsb_bits", 32'(cap_l[7:0]),  32'h0A5);
      check("a5_last",     32'(last_m[7:0]), 32'h01);
      check("a5_ready",    32'(m_ready),     32'd1);

      // 0x01: LSB-first sends the set bit first.
      clear_cap();
      accept(8'h01);
      repeat (8) tick();
      settle();
      check("x01_lsb_bits", 32'(cap_l[7:0]), 32'h80);
      check("x01_msb_bits", 32'(cap_m[7:0]), 32'h01);

      // 0xF0 with enable pattern 1,0,0,1; a stray in_valid mid-frame.
      clear_cap();
      in_enable = 1'b0;
      accept(8'hF0);
      ens = 0;
      for (int i = 0; i < 40 && ens < 8; i++) begin
         in_enable = (i % 4 == 0) || (i % 4 == 3);
         in_valid  = (i == 1);
         in_data   = (i == 1) ? 8'h3C : 8'hF0;
         tick();
         if (in_enable) ens++;
      end
      in_valid  = 1'b0;
      in_enable = 1'b0;
      settle();
      check("f0_enables",  32'(ens),        32'd8);
      check("f0_count",    32'(ncap),       32'd8);
      check("f0_msb_bits", 32'(cap_m[7:0]), 32'hF0);
      check("f0_lsb_bits", 32'(cap_l[7:0]), 32'h0F);
      check("f0_idle",     32'(m_valid),    32'd0);

      // Back-to-back 0xFF then 0x00.
      clear_cap();
      in_enable = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      tick();
      in_data   = 8'h00;
      repeat (8) tick();
      in_valid  = 1'b0;
      repeat (8) tick();
      settle();
      check("b2b_count",  32'(ncap),   32'd16);
      check("b2b_vcyc",   32'(vcnt),   32'd16);
      check("b2b_bits_m", 32'(cap_m),  32'hFF00);
      check("b2b_bits_l", 32'(cap_l),  32'hFF00);
      check("b2b_last",   32'(last_m), 32'h0101);

      // Reset mid-frame after 3 bits of 0xC3.
      clear_cap();
      accept(8'hC3);
      repeat (3) tick();
      check("c3_bits", 32'(cap_m[2:0]), 32'h6);
      in_reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_ready", 32'(m_ready), 32'd0);
      tick();
      in_reset_n = 1'b1;
      in_enable  = 1'b0;
      settle();
      check("rel_ready", 32'(m_ready), 32'd1);
      check("rel_valid", 32'(l_valid), 32'd0);
`else
      // Parity build: 0x07 gives 8 data bits then parity 1.
      clear_cap();
      in_enable = 1'b1;
      accept(8'h07);
      repeat (8) tick();
      check("par_valid", 32'(m_valid), 32'd1);
      check("par_bit",   32'(m_bit),   32'd1);
      check("par_last",  32'(m_last),  32'd1);
      check("par_ready", 32'(m_ready), 32'd0);
      check("par_data_m", 32'(cap_m[7:0]), 32'h07);
      check("par_data_l", 32'(cap_l[7:0]), 32'hE0);
      check("par_nolast", 32'(last_m[7:0]), 32'h00);
      tick();
      settle();
      check("par_count",  32'(ncap),        32'd9);
      check("par_frame",  32'(cap_m[8:0]),  32'h00F);
      check("par_lastpos", 32'(last_m[8:0]), 32'h001);
      check("par_idle_ready", 32'(m_ready), 32'd1);
      check("par_idle_valid", 32'(m_valid), 32'd0);
`endif

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits, legal range 2..64.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit DATA_W-1 transmitted first, 0 = bit 0 transmitted first.
REQ-003 SHALL have port in_clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port in_reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  in_data holds a word to load.
REQ-006 SHALL have port in_data  input  DATA_W  parallel word.
REQ-007 SHALL have port out_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_enable  input  1  shift strobe; the bit currently on out_bit is consumed this cycle.
REQ-009 SHALL have port out_bit  output  1  current serial bit.
REQ-010 SHALL have port out_bit_valid  output  1  out_bit carries a meaningful bit.
REQ-011 SHALL have port out_last  output  1  out_bit is the final bit of the current frame.

Function
REQ-012 SHALL implement states IDLE, SHIFT and, when the feature is compiled in, PARITY.
REQ-013 SHALL accept a word when in_valid && out_ready; load shift register and bit counter = DATA_W-1; next state SHIFT.
REQ-014 SHALL drive out_ready = 1 in IDLE; in SHIFT only when the last bit is being consumed (counter==0 && in_enable) and parity is compiled out; 0 in PARITY.
REQ-015 SHALL, when a word is accepted while the last bit is consumed, go from SHIFT to SHIFT with no gap cycle (back-to-back frames).
REQ-016 SHALL drive first bit on out_bit in the cycle after acceptance, per MSB_FIRST.
REQ-017 SHALL, in SHIFT with in_enable=1, advance to the next bit (shift toward MSB if MSB_FIRST, else toward LSB) and decrement the counter.
REQ-018 SHALL, in SHIFT with in_enable=0, hold out_bit, counter and state unchanged.
REQ-019 SHALL, on counter==0 && in_enable, go to PARITY if compiled in, else SHIFT on a new accept, else IDLE.
REQ-020 SHALL assert out_bit_valid in SHIFT and PARITY only; in IDLE out_bit = 0 and out_bit_valid = 0.
REQ-021 SHALL assert out_last when counter==0 in SHIFT without parity, or in PARITY with parity.
REQ-022 SHALL ignore in_valid when out_ready = 0; in_data is not captured.
REQ-023 SHALL give no special meaning to in_enable in IDLE; it has no effect there.

Reset
REQ-024 SHALL, on in_reset_n low (any time, including mid-frame), force state IDLE, shift register 0, counter 0, parity accumulator 0.
REQ-025 SHALL, during reset, drive out_bit=0, out_bit_valid=0, out_last=0 and out_ready=0.
REQ-026 SHALL, after reset deassertion, raise out_ready in the first cycle, with no partial frame transmitted.

Configuration
REQ-027 SHALL, with macro PISO_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of all DATA_W data bits) as the final frame bit in state PARITY.
REQ-028 SHALL hold in PARITY until in_enable; then go to IDLE. The parity bit carries out_last=1 and no back-to-back accept.
REQ-029 SHALL, with PISO_SERIALIZER_PARITY_EN undefined, contain no PARITY state and no parity logic; the frame is exactly DATA_W bits.

Structure
REQ-030 SHALL take the state enum (IDLE, SHIFT, PARITY) and the counter-width function clog2(DATA_W) from shared package serializer_pkg.
REQ-031 SHALL keep the bit counter in sub-module serializer_bit_counter (load, decrement-on-enable, zero flag); the shift register and FSM stay in piso_serializer.

Verification
REQ-032 SHALL cover: reset, DATA_W=8, MSB_FIRST=1, accept 0xA5, in_enable held 1 -> out_bit 1,0,1,0,0,1,0,1; out_last only on 8th bit; out_ready=1 next cycle.
REQ-033 SHALL cover: MSB_FIRST=0, accept 0x01 -> out_bit 1,0,0,0,0,0,0,0.
REQ-034 SHALL cover: in_enable toggling 1,0,0,1 during 0xF0 -> each bit held while in_enable=0; frame completes after exactly 8 in_enable=1 cycles.
REQ-035 SHALL cover: back-to-back 0xFF then 0x00, in_valid held 1 -> 16 contiguous valid bits, no gap, out_last on bits 8 and 16.
REQ-036 SHALL cover: in_reset_n pulsed low after bit 3 of 0xC3 -> out_bit_valid=0 immediately; after release, IDLE with out_ready=1.
REQ-037 SHALL cover: PISO_SERIALIZER_PARITY_EN defined, accept 0x07 -> 8 data bits then parity 1 with out_last=1; out_ready=0 until return to IDLE.
